// File: rtl/tx_frame_packer.sv
// Write-side framer feeding an async FIFO: wraps each input frame as SOF, payload, XOR checksum.
// Frames longer than MAX_LEN are truncated and flagged, and the rest of that input frame is discarded.
module tx_frame_packer #(
  parameter int                 DATA_W   = 8,
  parameter int                 MAX_LEN  = 16,
  parameter logic [DATA_W-1:0]  SOF_BYTE = 8'hA5,
  parameter int                 CNT_W    = 8
) (
  input  logic              trans_clk,
  input  logic              trans_rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  input  logic              in_last,
  input  logic              fifo_full,
  output logic              write_enable,
  output logic [DATA_W-1:0] trans_data,
  output logic [CNT_W-1:0]  frame_count,
  output logic              overlen
);

  localparam int LEN_W = $clog2(MAX_LEN + 1);

  typedef enum logic [1:0] {IDLE, PAYLOAD, CSUM, DROP} state_t;

  state_t            state_reg, state_next;
  logic              we_reg;
  logic [DATA_W-1:0] data_reg;
  logic [CNT_W-1:0]  count_reg;
  logic              overlen_reg, overlen_next;
  logic [DATA_W-1:0] csum_reg, csum_next;
  logic [LEN_W-1:0]  len_reg, len_next;
  logic              drop_reg, drop_next;

  logic              accept;
  logic              slot_free;
  logic              fire;
  logic [LEN_W-1:0]  len_inc;
  logic              at_max;
  logic              load;
  logic [DATA_W-1:0] load_data;
  logic              count_inc;

  // The output slot can take a new byte when empty or when its current byte leaves this cycle.
  assign accept    = we_reg & ~fifo_full;
  assign slot_free = ~we_reg | accept;
  assign fire      = in_valid & in_ready;
  assign len_inc   = len_reg + LEN_W'(1);
  assign at_max    = (len_inc == LEN_W'(MAX_LEN));

  always_comb begin
    in_ready = 1'b0;
    case (state_reg)
      PAYLOAD: in_ready = slot_free;
      DROP:    in_ready = 1'b1;
      default: in_ready = 1'b0;
    endcase
  end

  always_ff @(posedge trans_clk or negedge trans_rst) begin
    if (!trans_rst) begin
      state_reg <= IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE: begin
        if (in_valid && slot_free) state_next = PAYLOAD;
      end
      PAYLOAD: begin
        if (fire && (in_last || at_max)) state_next = CSUM;
      end
      CSUM: begin
        if (slot_free) state_next = drop_reg ? DROP : IDLE;
      end
      DROP: begin
        if (in_valid && in_last) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    load         = 1'b0;
    load_data    = csum_reg;
    csum_next    = csum_reg;
    len_next     = len_reg;
    drop_next    = drop_reg;
    overlen_next = 1'b0;
    count_inc    = 1'b0;
    case (state_reg)
      IDLE: begin
        if (in_valid && slot_free) begin
          load      = 1'b1;
          load_data = SOF_BYTE;
          csum_next = '0;
          len_next  = '0;
        end
      end
      PAYLOAD: begin
        if (fire) begin
          load      = 1'b1;
          load_data = in_data;
          csum_next = csum_reg ^ in_data;
          len_next  = len_inc;
          // A last byte landing exactly on MAX_LEN is a normal frame end, not a truncation.
          if (!in_last && at_max) begin
            drop_next    = 1'b1;
            overlen_next = 1'b1;
          end
        end
      end
      CSUM: begin
        if (slot_free) begin
          load      = 1'b1;
          load_data = csum_reg;
          count_inc = 1'b1;
          drop_next = 1'b0;
        end
      end
      default: begin
        load = 1'b0;
      end
    endcase
  end

  always_ff @(posedge trans_clk or negedge trans_rst) begin
    if (!trans_rst) begin
      we_reg      <= 1'b0;
      data_reg    <= '0;
      count_reg   <= '0;
      overlen_reg <= 1'b0;
      csum_reg    <= '0;
      len_reg     <= '0;
      drop_reg    <= 1'b0;
    end else begin
      // data_reg only changes on a load, so a stalled byte stays stable while the FIFO is full.
      if (load) begin
        we_reg   <= 1'b1;
        data_reg <= load_data;
      end else if (accept) begin
        we_reg   <= 1'b0;
      end
      if (count_inc) count_reg <= count_reg + CNT_W'(1);
      overlen_reg <= overlen_next;
      csum_reg    <= csum_next;
      len_reg     <= len_next;
      drop_reg    <= drop_next;
    end
  end

  assign write_enable = we_reg;
  assign trans_data   = data_reg;
  assign frame_count  = count_reg;
  assign overlen      = overlen_reg;

endmodule

// File: doc/tx_frame_packer.md
Name: tx_frame_packer

Overview:
- Write-side framer in the trans_clk domain, directly upstream of the async FIFO write port.
- Accepts a byte stream with valid/ready/last and writes frames into the FIFO: SOF byte, payload bytes, then an XOR checksum byte.
- Honours fifo_full by holding its registered write request, so no byte is lost or duplicated.
- Truncates frames longer than MAX_LEN and flags them.

Parameters:
- DATA_W, 8, byte width; equals the FIFO data bus width.
- MAX_LEN, 16, maximum payload bytes per frame (>=1).
- SOF_BYTE, 8'hA5, start-of-frame marker.
- CNT_W, 8, width of frame_count.

Ports:
- trans_clk  in  1  write-domain clock; all logic on its rising edge.
- trans_rst  in  1  asynchronous, active-low reset.
- in_valid  in  1  upstream byte valid.
- in_ready  out  1  upstream byte accepted when in_valid & in_ready.
- in_data  in  DATA_W  upstream payload byte.
- in_last  in  1  marks the final payload byte of a frame.
- fifo_full  in  1  FIFO full flag.
- write_enable  out  1  FIFO write request.
- trans_data  out  DATA_W  FIFO write data.
- frame_count  out  CNT_W  frames completed; wraps.
- overlen  out  1  one-cycle pulse when a frame is truncated.

Behaviour:
- Reset (trans_rst=0, async): state=IDLE; write_enable=0; trans_data=0; frame_count=0; overlen=0; csum=0; len=0; drop_pend=0.
- Output slot: write_enable/trans_data form a register.
  - accept = write_enable & ~fifo_full.
  - slot_free = ~write_enable | accept.
  - On accept with no new load, write_enable drops to 0 next cycle.
  - While write_enable=1 and fifo_full=1, trans_data is held stable.
- in_ready = slot_free in PAYLOAD, 1 in DROP, 0 otherwise. It is combinational from fifo_full.
- IDLE:
  - If in_valid & slot_free: load SOF_BYTE, csum<=0, len<=0, go to PAYLOAD.
  - The first payload byte is not consumed in that cycle.
- PAYLOAD: on in_valid & in_ready:
  - load in_data; csum<=csum^in_data; len<=len+1.
  - If in_last: go to CSUM.
  - Else if len+1==MAX_LEN: set drop_pend=1, pulse overlen, go to CSUM.
- CSUM:
  - When slot_free: load csum; frame_count<=frame_count+1.
  - Then go to DROP if drop_pend, else IDLE; clear drop_pend.
- DROP:
  - Consume and discard input bytes.
  - On in_valid & in_last, go to IDLE.
  - No FIFO writes occur in DROP.
- Simultaneous in_last and len+1==MAX_LEN: treat as a normal end of frame; no overlen, no DROP.
- Latency: SOF appears on write_enable 1 cycle after in_valid is seen in IDLE with slot_free.
- Throughput: one byte/cycle while fifo_full=0. A frame of N<=MAX_LEN bytes produces exactly N+2 FIFO writes.
- Wrap: frame_count wraps 2^CNT_W-1 -> 0. len is wide enough for MAX_LEN.
- Reset mid-frame: all state clears immediately. Bytes already written are not retracted; the downstream consumer resynchronises on SOF.
- Behaviour with X on in_data when in_valid=0 is don't-care. Outputs never go X after reset.

Test Plan:
1. Reset, then a 3-byte frame 11,22,33 (last on 33), fifo_full=0 -> FIFO writes A5,11,22,33,00 (11^22^33=00) on consecutive cycles; frame_count=1; overlen never 1.
2. 1-byte frame 5A with fifo_full=1 for 4 cycles while A5 is pending -> write_enable stays 1 and trans_data stays A5 throughout; in_ready=0. After release, writes are A5,5A,5A.
3. 20-byte frame 01..14 (last on 14), MAX_LEN=16 -> writes A5, 01..10, then the XOR of 01..10 (=10). overlen pulses once. Bytes 11..14 are consumed with in_ready=1 and not written. frame_count=1.
4. Exactly 16-byte frame with in_last on byte 16 -> 18 writes, no overlen, returns to IDLE (no DROP).
5. Back-to-back frames 2 bytes + 2 bytes with in_valid held high -> A5,a,b,cs,A5,c,d,cs with only the SOF-load bubble on the input side; frame_count=2.
6. trans_rst asserted mid-payload (after 2 bytes) -> write_enable=0 and frame_count=0 immediately. The next frame starts with A5 and its csum is independent of the aborted frame.
